// File: rtl/unidade_controle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, instruction
// fields, ALU operations and datapath mux selects.
package unidade_controle_pkg;

   typedef enum logic [3:0] {
      ST_RESET     = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_EXEC_R    = 4'd3,
      ST_WB_R      = 4'd4,
      ST_EXEC_I    = 4'd5,
      ST_WB_I      = 4'd6,
      ST_MEM_ADDR  = 4'd7,
      ST_MEM_READ  = 4'd8,
      ST_MEM_WB    = 4'd9,
      ST_MEM_WRITE = 4'd10,
      ST_BRANCH    = 4'd11,
      ST_JUMP      = 4'd12,
      ST_JR        = 4'd13,
      ST_EXC       = 4'd14
   } estado_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_XOR = 6'h26;

   localparam logic [2:0] ALU_LOADA = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_XOR   = 3'b110;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_4     = 2'd1;
   localparam logic [1:0] SRCB_EXT   = 2'd2;
   localparam logic [1:0] SRCB_EXTSH = 2'd3;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_EXC    = 2'd3;

   function automatic logic [2:0] alu_funct(input logic [5:0] f);
      case (f)
         FN_ADD:  return ALU_ADD;
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_XOR:  return ALU_XOR;
         default: return ALU_LOADA;
      endcase
   endfunction

endpackage

// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS control unit: registered state and wait counter, with a
// combinational decode of every datapath strobe and select from the current state.
module unidade_controle_mc
   import unidade_controle_pkg::*;
#(
   parameter int unsigned MEM_WAIT   = 0,
   parameter bit          ENABLE_EXC = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       Overflow,
   output logic       PC_Escreve,
   output logic       IorD,
   output logic       Mem_Wr,
   output logic       IR_Load,
   output logic       MDR_Load,
   output logic       RegWrite,
   output logic       A_Load,
   output logic       B_Load,
   output logic       ALUOut_Load,
   output logic       EPC_Load,
   output logic       ALUSrcA,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALU_Sel,
   output logic [3:0] Estado
);

   localparam logic [3:0] ESPERA_FIM = 4'(MEM_WAIT);

   estado_t    estado_q, estado_d;
   logic [3:0] espera_q, espera_d;
   logic       ultimo;
   logic       r_valido;
   logic       r_aritm;

   assign ultimo   = (espera_q == ESPERA_FIM);
   assign r_aritm  = (Funct == FN_ADD) || (Funct == FN_SUB);
   assign r_valido = r_aritm || (Funct == FN_AND) || (Funct == FN_XOR);
   assign Estado   = estado_q;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         estado_q <= ST_RESET;
         espera_q <= '0;
      end else begin
         estado_q <= estado_d;
         espera_q <= espera_d;
      end
   end

   always_comb begin
      estado_d    = estado_q;
      espera_d    = '0;
      PC_Escreve  = 1'b0;
      IorD        = 1'b0;
      Mem_Wr      = 1'b0;
      IR_Load     = 1'b0;
      MDR_Load    = 1'b0;
      RegWrite    = 1'b0;
      A_Load      = 1'b0;
      B_Load      = 1'b0;
      ALUOut_Load = 1'b0;
      EPC_Load    = 1'b0;
      ALUSrcA     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSource    = PCS_ALU;
      ALU_Sel     = ALU_LOADA;

      case (estado_q)
         ST_RESET: estado_d = ST_FETCH;

         ST_FETCH: begin
            ALUSrcB = SRCB_4;
            ALU_Sel = ALU_ADD;
            if (ultimo) begin
               IR_Load    = 1'b1;
               PC_Escreve = 1'b1;
               estado_d   = ST_DECODE;
            end else begin
               espera_d = espera_q + 4'd1;
            end
         end

         // Branch target PC+(ext<<2) is latched into ALUOut here, ahead of BRANCH.
         ST_DECODE: begin
            A_Load      = 1'b1;
            B_Load      = 1'b1;
            ALUOut_Load = 1'b1;
            ALUSrcB     = SRCB_EXTSH;
            ALU_Sel     = ALU_ADD;
            case (Opcode)
               OP_RTYPE: begin
                  if (Funct == FN_JR)  estado_d = ST_JR;
                  else if (r_valido)   estado_d = ST_EXEC_R;
                  else                 estado_d = ENABLE_EXC ? ST_EXC : ST_FETCH;
               end
               OP_ADDI:      estado_d = ST_EXEC_I;
               OP_LW, OP_SW: estado_d = ST_MEM_ADDR;
               OP_BEQ, OP_BNE: estado_d = ST_BRANCH;
               OP_J:         estado_d = ST_JUMP;
               default:      estado_d = ENABLE_EXC ? ST_EXC : ST_FETCH;
            endcase
         end

         ST_EXEC_R: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_B;
            ALU_Sel     = alu_funct(Funct);
            ALUOut_Load = 1'b1;
            estado_d    = (ENABLE_EXC && Overflow && r_aritm) ? ST_EXC : ST_WB_R;
         end

         ST_WB_R: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            estado_d = ST_FETCH;
         end

         ST_EXEC_I: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_EXT;
            ALU_Sel     = ALU_ADD;
            ALUOut_Load = 1'b1;
            estado_d    = (ENABLE_EXC && Overflow) ? ST_EXC : ST_WB_I;
         end

         ST_WB_I: begin
            RegWrite = 1'b1;
            estado_d = ST_FETCH;
         end

         ST_MEM_ADDR: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_EXT;
            ALU_Sel     = ALU_ADD;
            ALUOut_Load = 1'b1;
            estado_d    = (Opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         end

         ST_MEM_READ: begin
            IorD = 1'b1;
            if (ultimo) begin
               MDR_Load = 1'b1;
               estado_d = ST_MEM_WB;
            end else begin
               espera_d = espera_q + 4'd1;
            end
         end

         ST_MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            estado_d = ST_FETCH;
         end

         ST_MEM_WRITE: begin
            IorD   = 1'b1;
            Mem_Wr = 1'b1;
            if (ultimo) estado_d = ST_FETCH;
            else        espera_d = espera_q + 4'd1;
         end

         ST_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_B;
            ALU_Sel    = ALU_SUB;
            PCSource   = PCS_ALUOUT;
            PC_Escreve = (Opcode == OP_BEQ) ? Zero : !Zero;
            estado_d   = ST_FETCH;
         end

         ST_JUMP: begin
            PCSource   = PCS_JUMP;
            PC_Escreve = 1'b1;
            estado_d   = ST_FETCH;
         end

         ST_JR: begin
            ALUSrcA    = 1'b1;
            ALU_Sel    = ALU_LOADA;
            PCSource   = PCS_ALU;
            PC_Escreve = 1'b1;
            estado_d   = ST_FETCH;
         end

         // PC already points past the faulting instruction, so EPC gets PC-4.
         ST_EXC: begin
            EPC_Load   = 1'b1;
            ALUSrcB    = SRCB_4;
            ALU_Sel    = ALU_SUB;
            PCSource   = PCS_EXC;
            PC_Escreve = 1'b1;
            estado_d   = ST_FETCH;
         end

         default: estado_d = ST_RESET;
      endcase
   end

endmodule
